// File: rtl/eight_bit_prime_generator.sv
// Serial trial-division prime generator: sweeps START..LIMIT, streams each candidate MSB-first
// through mod-2/3/5/7/11/13 residue trackers and hands primes out on a valid/ready port.
// Optional macro PRIME_GEN_SKIP_EVEN_EN: skip even candidates above 2.
module eight_bit_prime_generator #(
    parameter logic [7:0] START = 8'd2,
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ready,
    output logic [7:0] prime_out,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic [5:0] count
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        EMIT,
        DONE
    } state_t;

    localparam logic [5:0][4:0] MODULI = {5'd13, 5'd11, 5'd7, 5'd5, 5'd3, 5'd2};

    state_t          state;
    state_t          state_next;
    logic [7:0]      cand;
    logic [7:0]      cand_next;
    logic [7:0]      prime_next;
    logic [2:0]      idx;
    logic [2:0]      idx_next;
    logic [5:0][3:0] res;
    logic [5:0][3:0] res_next;
    logic [5:0]      count_next;
    logic [8:0]      step;
    logic [8:0]      advanced;
    logic            last;
    logic            is_prime;
    logic            bit_in;

    // Residue r < p, so 2r+b < 2p and a single conditional subtract reduces it.
    function automatic logic [3:0] mod_step(input logic [3:0] r, input logic b, input logic [4:0] p);
        logic [4:0] t;
        t = {r, b};
        if (t >= p) begin
            t = t - p;
        end
        return t[3:0];
    endfunction

    always_comb begin
`ifdef PRIME_GEN_SKIP_EVEN_EN
        step = (cand < 8'd2 || !cand[0]) ? 9'd1 : 9'd2;
`else
        step = 9'd1;
`endif
        advanced = {1'b0, cand} + step;
        // Checked before advancing, so the candidate never wraps past 255.
        last     = (cand >= LIMIT) || (advanced > {1'b0, LIMIT});
    end

    always_comb begin
        is_prime = (cand >= 8'd2);
        for (int i = 0; i < 6; i++) begin
            if (res[i] == 4'd0 && cand != {3'b000, MODULI[i]}) begin
                is_prime = 1'b0;
            end
        end
    end

    assign bit_in = cand[idx];

    always_comb begin
        state_next = state;
        cand_next  = cand;
        idx_next   = idx;
        res_next   = res;
        prime_next = prime_out;
        count_next = count;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = SHIFT;
                    cand_next  = START;
                    idx_next   = 3'd7;
                    res_next   = '0;
                    count_next = '0;
                end
            end
            SHIFT: begin
                for (int i = 0; i < 6; i++) begin
                    res_next[i] = mod_step(res[i], bit_in, MODULI[i]);
                end
                idx_next = idx - 3'd1;
                if (idx == 3'd0) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (is_prime) begin
                    state_next = EMIT;
                    prime_next = cand;
                end else if (last) begin
                    state_next = DONE;
                end else begin
                    state_next = SHIFT;
                    cand_next  = advanced[7:0];
                    idx_next   = 3'd7;
                    res_next   = '0;
                end
            end
            EMIT: begin
                if (ready) begin
                    count_next = (count == 6'd63) ? count : count + 6'd1;
                    if (last) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                        cand_next  = advanced[7:0];
                        idx_next   = 3'd7;
                        res_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All state advances on the falling clock edge.
    always_ff @(negedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= 8'd0;
            idx       <= 3'd0;
            res       <= '0;
            prime_out <= 8'd0;
            count     <= 6'd0;
        end else begin
            state     <= state_next;
            cand      <= cand_next;
            idx       <= idx_next;
            res       <= res_next;
            prime_out <= prime_next;
            count     <= count_next;
        end
    end

    assign valid = (state == EMIT);
    assign busy  = (state == SHIFT) || (state == CHECK) || (state == EMIT);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_eight_bit_prime_generator.sv
// Bench for eight_bit_prime_generator: two instances (2..255 and 0..12) checked against a
// trial-division prime model with randomized backpressure and stray start pulses.
module tb_eight_bit_prime_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_full;
    logic       start_small;
    logic       ready;
    logic [7:0] f_prime;
    logic       f_valid;
    logic       f_busy;
    logic       f_done;
    logic [5:0] f_count;
    logic [7:0] s_prime;
    logic       s_valid;
    logic       s_busy;
    logic       s_done;
    logic [5:0] s_count;

    logic       sel;
    logic [7:0] cur_prime;
    logic       cur_valid;
    logic       cur_busy;
    logic       cur_done;
    logic [5:0] cur_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q[$];

    eight_bit_prime_generator dut_full (
        .clk       (clk),
        .reset     (reset),
        .start     (start_full),
        .ready     (ready),
        .prime_out (f_prime),
        .valid     (f_valid),
        .busy      (f_busy),
        .done      (f_done),
        .count     (f_count)
    );

    eight_bit_prime_generator #(.START(8'd0), .LIMIT(8'd12)) dut_small (
        .clk       (clk),
        .reset     (reset),
        .start     (start_small),
        .ready     (ready),
        .prime_out (s_prime),
        .valid     (s_valid),
        .busy      (s_busy),
        .done      (s_done),
        .count     (s_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        cur_prime = sel ? s_prime : f_prime;
        cur_valid = sel ? s_valid : f_valid;
        cur_busy  = sel ? s_busy  : f_busy;
        cur_done  = sel ? s_done  : f_done;
        cur_count = sel ? s_count : f_count;
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic bit model_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int model_next(input int c);
`ifdef PRIME_GEN_SKIP_EVEN_EN
        return (c < 2 || c % 2 == 0) ? c + 1 : c + 2;
`else
        return c + 1;
`endif
    endfunction

    task automatic build_expected(input int lo, input int hi);
        exp_q.delete();
        for (int n = lo; n <= hi; n++) begin
            if (model_prime(n)) exp_q.push_back(n);
        end
    endtask

    task automatic pulse_start();
        if (sel) start_small = 1'b1;
        else start_full = 1'b1;
        @(posedge clk);
        start_small = 1'b0;
        start_full  = 1'b0;
    endtask

    // Returns number of active edges seen from the start-sampling edge to first valid.
    task automatic start_and_measure(output int lat);
        pulse_start();
        lat = 1;
        check_output("busy_after_start", cur_busy, 1);
        while (!cur_valid && lat < 40) begin
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic wait_for_prime(input int value, input int budget);
        int n = 0;
        while (!(cur_valid && cur_prime == value) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_output($sformatf("reach_%0d", value), 32'(cur_valid && cur_prime == value), 1);
    endtask

    // Consumes the remainder of a sweep, comparing each handshake against exp_q.
    task automatic run_sweep(input int expected_count, input int budget, input bit rnd);
        int   cycles = 0;
        bit   held   = 1'b0;
        int   held_val = 0;
        bit   r;
        while (!cur_done && cycles < budget) begin
            if (held) begin
                check_output("hold_valid", cur_valid, 1);
                check_output("hold_prime", cur_prime, held_val);
            end
            r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            ready = r;
            if (rnd && cur_busy && $urandom_range(0, 15) == 0) begin
                if (sel) start_small = 1'b1;
                else start_full = 1'b1;
            end
            if (cur_valid && r) begin
                check_output("expected_left", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check_output("emit_value", cur_prime, exp_q.pop_front());
            end
            held     = cur_valid && !r;
            held_val = cur_prime;
            @(posedge clk);
            start_full  = 1'b0;
            start_small = 1'b0;
            cycles++;
        end
        ready = 1'b1;
        check_output("sweep_done", cur_done, 1);
        check_output("sweep_busy", cur_busy, 0);
        check_output("sweep_valid", cur_valid, 0);
        check_output("sweep_count", cur_count, expected_count);
        check_output("sweep_leftover", exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int c;
        int off;
        reset       = 1'b1;
        start_full  = 1'b0;
        start_small = 1'b0;
        ready       = 1'b1;
        sel         = 1'b0;
        repeat (3) @(posedge clk);
        check_output("reset_prime", f_prime, 0);
        check_output("reset_valid", f_valid, 0);
        check_output("reset_busy", f_busy, 0);
        check_output("reset_done", f_done, 0);
        check_output("reset_count", f_count, 0);
        check_output("reset_small_busy", s_busy, 0);
        reset = 1'b0;
        @(posedge clk);

        // Full sweep with ready held high, including first-output latency.
        build_expected(2, 255);
        start_and_measure(lat);
        check_output("first_valid_latency", lat, 10);
        check_output("first_prime", cur_prime, 2);
        run_sweep(54, 10000, 1'b0);

        // Backpressure while 7 is on the port.
        build_expected(2, 255);
        pulse_start();
        check_output("restart_clears_done", cur_done, 0);
        wait_for_prime(7, 200);
        ready = 1'b0;
        repeat (20) begin
            @(posedge clk);
            check_output("bp_valid", cur_valid, 1);
            check_output("bp_prime", cur_prime, 7);
            check_output("bp_count", cur_count, 3);
        end
        ready = 1'b1;
        @(posedge clk);
        while (exp_q.size() > 0 && exp_q[0] != 11) void'(exp_q.pop_front());
        wait_for_prime(11, 100);
        check_output("after_bp_count", cur_count, 4);
        run_sweep(54, 10000, 1'b1);

        // Small range 0..12 with random backpressure.
        sel = 1'b1;
        build_expected(0, 12);
        start_and_measure(lat);
        check_output("small_latency_bound", 32'(lat < 40), 1);
        run_sweep(5, 2000, 1'b1);
        sel = 1'b0;

        // Reset on the third SHIFT edge of candidate 23, coincident with a start pulse.
        pulse_start();
        wait_for_prime(19, 500);
        c   = model_next(19);
        off = 0;
        while (c < 23) begin
            off += 9;
            c = model_next(c);
        end
        repeat (off + 3) @(posedge clk);
        check_output("pre_reset_busy", f_busy, 1);
        check_output("pre_reset_valid", f_valid, 0);
        check_output("pre_reset_count", f_count, 8);
        reset      = 1'b1;
        start_full = 1'b1;
        @(posedge clk);
        start_full = 1'b0;
        check_output("mid_reset_prime", f_prime, 0);
        check_output("mid_reset_valid", f_valid, 0);
        check_output("mid_reset_busy", f_busy, 0);
        check_output("mid_reset_done", f_done, 0);
        check_output("mid_reset_count", f_count, 0);
        @(posedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            check_output("idle_valid", f_valid, 0);
            check_output("idle_busy", f_busy, 0);
        end

        // Fresh sweep after reset, random backpressure and ignored start pulses.
        build_expected(2, 255);
        start_and_measure(lat);
        check_output("fresh_latency", lat, 10);
        check_output("fresh_first_prime", cur_prime, 2);
        run_sweep(54, 12000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
